fpu_vector_checker: RTL
=======================

Name: fpu_vector_checker

Overview:
- Synthesizable, parametrised self-checking vector engine for the fpu block.
- Holds a loadable vector memory, replays each vector into the fpu (funct, a, b), waits for finish and compares the result to the expected value with a configurable ULP tolerance.
- Counts errors and reports the first failing index.
- Sits beside the fpu for on-chip BIST and for FPGA bring-up. It replaces the behavioural bench flow with a cycle-accurate one.

Parameters:
- DEPTH, 1024, number of vector entries.
- AW, $clog2(DEPTH), vector address width.
- ULP_TOL, 1, maximum allowed |result - expected| in ULPs, same sign only.
- TIMEOUT, 64, cycles to wait for dut_finish before a vector is flagged as failed.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  vector memory write strobe; ignored while busy.
- wr_addr  in  AW  vector write address.
- wr_data  in  100  vector word: [99] skip, [98] reserved, [97:96] funct, [95:64] a, [63:32] b, [31:0] expected.
- num_vec  in  AW+1  number of vectors to run, 0..DEPTH; sampled on start.
- start  in  1  one-cycle run request; ignored while busy.
- dut_funct  out  2  operation to fpu.
- dut_a  out  32  operand a.
- dut_b  out  32  operand b.
- dut_start  out  1  one-cycle issue pulse to fpu.
- dut_o  in  32  fpu result.
- dut_finish  in  1  fpu result-valid level/pulse.
- busy  out  1  run in progress.
- done  out  1  run completed; held until next start.
- vec_count  out  AW+1  vectors completed in current/last run.
- err_count  out  AW+1  failing vectors, saturating at DEPTH.
- first_err  out  AW  index of first failing vector; valid when err_count != 0.
- timeout_err  out  1  sticky; set if any vector timed out.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Vector memory contents are not reset.
- Reset asserted mid-run aborts the run at the next edge; no done is produced.
- States and transitions:
  - IDLE: on start, clear done, counters, first_err and timeout_err; latch num_vec; set busy.
    - num_vec==0 -> DONE.
    - otherwise -> FETCH.
  - FETCH: synchronous memory read of entry idx; 1 cycle -> ISSUE.
  - ISSUE:
    - If skip bit set: vec_count+1, no dut_start -> NEXT.
    - Else drive dut_funct/a/b (held stable until the next ISSUE), pulse dut_start for 1 cycle, clear timer -> WAIT.
  - WAIT:
    - dut_finish high -> capture dut_o -> CHECK.
    - Timer reaching TIMEOUT-1 -> count error, set timeout_err -> NEXT.
    - dut_finish in the same cycle as timeout: finish wins.
  - CHECK: compare, update err_count/first_err, vec_count+1 -> NEXT.
  - NEXT: idx+1; if idx+1==num_vec -> DONE, else -> FETCH.
  - DONE: busy=0, done=1 -> IDLE.
- Latency per non-skipped vector = 3 + fpu latency + 1 cycles.
- Compare rules, in priority order:
  - Bit-equal -> pass.
  - Both NaN (exp==8'hFF, mantissa!=0) -> pass.
  - +0 vs -0 -> pass.
  - Sign differs -> fail.
  - Otherwise |result[30:0] - expected[30:0]| <= ULP_TOL -> pass; the subtraction is 31-bit unsigned magnitude of the difference.
- first_err is written only on the first failure of a run.
- err_count saturates at DEPTH and never wraps.
- wr_en while busy is dropped. wr_en and start in the same cycle in IDLE: the write is performed and the run starts reading from the next cycle.

Optional Feature:
- Macro FPU_CHK_LOG_EN.
- When defined: adds a 4-entry error-log FIFO. Each failure pushes {index[AW-1:0], timeout_flag, dut_o[31:0]}; pushes are dropped when the FIFO is full.
- Added ports:
  - log_rd  in  1  pops one entry.
  - log_valid  out  1  FIFO non-empty.
  - log_data  out  AW+33  entry at head of FIFO.
- The FIFO is cleared on start and on reset. log_rd when empty is ignored.
- When not defined: none of these ports or this logic exist, and the remaining behaviour is identical.

Test Plan:
- Load 3 vectors (add 1.0+2.0 exp 40400000, mul 2.0*3.0 exp 40C00000, sub 5.0-1.0 exp 40800000); fpu model exact; start num_vec=3 -> done=1, vec_count=3, err_count=0.
- Vector 1 expected 40C00001, model returns 40C00000, ULP_TOL=1 -> pass. Expected 40C00002 -> err_count=1, first_err=1.
- Model never asserts finish on vector 2 -> after TIMEOUT cycles timeout_err=1, err_count=1, first_err=2; run continues and done=1.
- Vector with skip=1 and a=FF800000 -> no dut_start pulse for it, vec_count still increments, no error.
- Result 80000000 vs expected 00000000 -> pass. Result 7FC00001 vs expected 7FC00000 -> pass. Result 3F800000 vs expected BF800000 -> fail.
- Assert rst_n=0 during WAIT of vector 1 -> next cycle busy=0, done=0, counters 0. Start with num_vec=0 -> done after 2 cycles, no dut_start.

Source files
------------

// File: rtl/fpu_vector_checker.sv
// Vector replay engine: feeds stored vectors to the fpu and checks results.
// Define FPU_CHK_LOG_EN to add a 4-entry error-log FIFO.
module fpu_vector_checker #(
  parameter int DEPTH   = 1024,
  parameter int AW      = $clog2(DEPTH),
  parameter int ULP_TOL = 1,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [99:0]   wr_data,
  input  logic [AW:0]   num_vec,
  input  logic          start,
  output logic [1:0]    dut_funct,
  output logic [31:0]   dut_a,
  output logic [31:0]   dut_b,
  output logic          dut_start,
  input  logic [31:0]   dut_o,
  input  logic          dut_finish,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   vec_count,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err,
  output logic          timeout_err
`ifdef FPU_CHK_LOG_EN
  ,
  input  logic          log_rd,
  output logic          log_valid,
  output logic [AW+32:0] log_data
`endif
);

  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] EMAX = CW'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [30:0] TOL = 31'(ULP_TOL);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  // Reserved bit [98] is not stored; word is {skip, funct, a, b, expected}
  logic [98:0]   mem [DEPTH];
  logic          unused_rsvd;

  state_t        state_q;
  logic [98:0]   rd_q;
  logic [AW:0]   idx_q;
  logic [AW:0]   num_q;
  logic [TW-1:0] timer_q;
  logic [31:0]   res_q;
  logic [1:0]    funct_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          start_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] vec_q;
  logic [CW-1:0] err_q;
  logic [CW-1:0] err_d;
  logic [AW-1:0] first_q;
  logic          to_q;
  logic          is_to;
  logic          fail_ev;
  logic          go;

  assign unused_rsvd = wr_data[98];
  assign go = (state_q == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (wr_en && state_q == S_IDLE)
      mem[wr_addr] <= {wr_data[99], wr_data[97:0]};
  end

  function automatic logic res_ok(input logic [31:0] r,
                                  input logic [31:0] e);
    logic       r_nan;
    logic       e_nan;
    logic [30:0] d;
    r_nan = (r[30:23] == 8'hFF) && (r[22:0] != '0);
    e_nan = (e[30:23] == 8'hFF) && (e[22:0] != '0);
    d = (r[30:0] >= e[30:0]) ? r[30:0] - e[30:0] : e[30:0] - r[30:0];
    if (r == e)                             return 1'b1;
    if (r_nan && e_nan)                     return 1'b1;
    if (r[30:0] == '0 && e[30:0] == '0)     return 1'b1;
    if (r[31] != e[31])                     return 1'b0;
    return d <= TOL;
  endfunction

  always_comb begin
    is_to   = (state_q == S_WAIT) && !dut_finish && (timer_q == TLAST);
    fail_ev = is_to ||
              ((state_q == S_CHECK) && !res_ok(res_q, rd_q[31:0]));
    err_d   = err_q;
    if (fail_ev && err_q != EMAX)
      err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      timer_q <= '0;
      res_q   <= '0;
      funct_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vec_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      to_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= err_d;
      if (fail_ev && err_q == '0)
        first_q <= idx_q[AW-1:0];
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            done_q  <= 1'b0;
            vec_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            to_q    <= 1'b0;
            num_q   <= num_vec;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (num_vec == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          rd_q    <= mem[idx_q[AW-1:0]];
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (rd_q[98]) begin
            vec_q   <= vec_q + 1'b1;
            state_q <= S_NEXT;
          end else begin
            funct_q <= rd_q[97:96];
            a_q     <= rd_q[95:64];
            b_q     <= rd_q[63:32];
            start_q <= 1'b1;
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dut_finish) begin
            res_q   <= dut_o;
            state_q <= S_CHECK;
          end else if (timer_q == TLAST) begin
            to_q    <= 1'b1;
            state_q <= S_NEXT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_CHECK: begin
          vec_q   <= vec_q + 1'b1;
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          idx_q   <= idx_q + 1'b1;
          state_q <= (idx_q + 1'b1 == num_q) ? S_DONE : S_FETCH;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_funct   = funct_q;
  assign dut_a       = a_q;
  assign dut_b       = b_q;
  assign dut_start   = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign vec_count   = vec_q;
  assign err_count   = err_q;
  assign first_err   = first_q;
  assign timeout_err = to_q;

`ifdef FPU_CHK_LOG_EN
  // Entry: {index, timeout flag, observed result}
  logic [AW+32:0] log_q [4];
  logic [2:0]     wp_q;
  logic [2:0]     rp_q;
  logic           log_full;
  logic           log_empty;

  assign log_full  = (wp_q - rp_q) == 3'd4;
  assign log_empty = (wp_q == rp_q);

  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (fail_ev && !log_full) begin
        log_q[wp_q[1:0]] <= {idx_q[AW-1:0], is_to, is_to ? dut_o : res_q};
        wp_q <= wp_q + 1'b1;
      end
      if (log_rd && !log_empty)
        rp_q <= rp_q + 1'b1;
    end
  end

  assign log_valid = !log_empty;
  assign log_data  = log_q[rp_q[1:0]];
`endif

endmodule
